mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer placed directly around the combinational Booth multiplier `mul` in the datapath.
- On `start` it latches two signed 32-bit operands and drives them to the multiplier.
- It waits a fixed settle time, then captures the 64-bit product into an internal Z register.
- It writes the product into the HI/LO register pair over two bus cycles, LO first, then pulses `done`.

Parameters:
- WIDTH, 32: operand width; the product is 2*WIDTH bits.
- SETTLE_CYCLES, 2: cycles operands are held stable before the product is sampled; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- clr_n  in  1  asynchronous active-low reset
- start  in  1  request a multiply; sampled only in IDLE
- op_a  in  WIDTH  multiplicand, two's complement
- op_b  in  WIDTH  multiplier, two's complement
- mul_a  out  WIDTH  registered multiplicand to the multiplier
- mul_b  out  WIDTH  registered multiplier to the multiplier
- mul_prod  in  2*WIDTH  product returned by the multiplier
- busy  out  1  high in every state except IDLE
- bus_out  out  WIDTH  data driven toward HI/LO during write cycles, else 0
- lo_we  out  1  LO write strobe
- hi_we  out  1  HI write strobe
- lo_out  out  WIDTH  LO register contents
- hi_out  out  WIDTH  HI register contents
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - clr_n low forces, asynchronously and regardless of clk: state=IDLE; mul_a, mul_b, Z, hi_out, lo_out, settle counter all 0.
  - All strobes, busy and done are 0.
  - Reset mid-operation aborts it; no partial HI/LO write survives.
- FSM (one-hot or encoded, implementer's choice): IDLE, SETTLE, WR_LO, WR_HI, DONE. All outputs are Moore, decoded from registered state.
- IDLE:
  - On a clk edge with start=1: mul_a<=op_a, mul_b<=op_b, cnt<=SETTLE_CYCLES-1, go SETTLE.
  - With start=0: stay in IDLE.
- SETTLE:
  - mul_a and mul_b are held constant.
  - Each edge with cnt!=0 decrements cnt.
  - The edge with cnt==0 does Z<=mul_prod and goes to WR_LO.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- WR_LO:
  - lo_we=1, bus_out=Z[WIDTH-1:0].
  - At the edge: lo_out<=Z[WIDTH-1:0], go to WR_HI.
- WR_HI:
  - hi_we=1, bus_out=Z[2*WIDTH-1:WIDTH].
  - At the edge: hi_out<=Z upper half, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
- Latency: with start sampled at edge 0, the phases occupy these cycles after edge 0:
  - SETTLE: cycles 1..S
  - WR_LO: cycle S+1
  - WR_HI: cycle S+2
  - DONE: cycle S+3
  - busy is high from cycle 1 through cycle S+3 inclusive.
  - A new start may be accepted at the first edge after DONE, i.e. one IDLE cycle minimum between operations.
- start while busy (including in DONE) is ignored; it is neither queued nor allowed to alter the operand registers.
- op_a/op_b changes after the accepting edge have no effect on the current result.
- Arithmetic:
  - The product is passed through bit-exact; no sign handling in this block.
  - HI receives bits [63:32] and LO bits [31:0], including sign-extension bits for negative products.
- hi_out/lo_out hold their values indefinitely between operations; only WR_HI/WR_LO and reset change them.
- lo_we and hi_we are never high in the same cycle.
- bus_out is 0 whenever neither strobe is high.

Test Plan:
- Basic: reset, then op_a=3, op_b=5, start for 1 cycle, S=2 → lo_we in cycle 3 with bus_out=0x0000000F, hi_we in cycle 4 with 0x00000000, done in cycle 5, lo_out=0xF, hi_out=0.
- Negative product: op_a=0xFFFFFFFE (−2), op_b=3 → lo_out=0xFFFFFFFA, hi_out=0xFFFFFFFF.
- Extreme operands: op_a=op_b=0x80000000 → hi_out=0x40000000, lo_out=0x00000000. Repeat with op_a=0x7FFFFFFF, op_b=0x80000000 → hi_out=0xC0000000, lo_out=0x80000000.
- Busy protection: start 7×6, then pulse start with 100×100 in cycle 2 and change op_a during SETTLE → result stays lo_out=42, only one done pulse.
- Reset mid-operation: start 9×9, assert clr_n low during SETTLE (between clock edges) → state IDLE immediately, all outputs 0, no write strobes. Then run 2×2 → lo_out=4.
- Parameter sweep: SETTLE_CYCLES=1 and 15 → done exactly S+3 cycles after the accepting edge. Back-to-back starts held high → operations complete with exactly one IDLE cycle between done and the next busy.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Sequencer wrapped around the combinational multiplier: latches operands, waits for the
// product to settle, captures it, then writes LO and HI over two bus cycles.
module mul_seq_ctrl #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 2   // legal range 1..15
) (
   input  logic               clk,
   input  logic               clr_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   input  logic [2*WIDTH-1:0] mul_prod,
   output logic               busy,
   output logic [WIDTH-1:0]   bus_out,
   output logic               lo_we,
   output logic               hi_we,
   output logic [WIDTH-1:0]   lo_out,
   output logic [WIDTH-1:0]   hi_out,
   output logic               done
);

   localparam int            CW       = 4;
   localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      WR_LO  = 3'd2,
      WR_HI  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] z;
   logic               accept;
   logic               settled;

   assign accept  = (state == IDLE) && start;
   assign settled = (state == SETTLE) && (cnt == '0);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SETTLE;
         SETTLE:  if (cnt == '0) state_nxt = WR_LO;
         WR_LO:   state_nxt = WR_HI;
         WR_HI:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operands only load on acceptance, so start while busy cannot disturb the multiplier inputs.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         mul_a <= '0;
         mul_b <= '0;
      end else if (accept) begin
         mul_a <= op_a;
         mul_b <= op_b;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)                          cnt <= '0;
      else if (accept)                     cnt <= CNT_INIT;
      else if (state == SETTLE && cnt != '0) cnt <= cnt - 1'b1;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)       z <= '0;
      else if (settled) z <= mul_prod;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         lo_out <= '0;
         hi_out <= '0;
      end else begin
         if (state == WR_LO) lo_out <= z[WIDTH-1:0];
         if (state == WR_HI) hi_out <= z[2*WIDTH-1:WIDTH];
      end
   end

   assign busy  = (state != IDLE);
   assign lo_we = (state == WR_LO);
   assign hi_we = (state == WR_HI);
   assign done  = (state == DONE);

   always_comb begin
      bus_out = '0;
      if (lo_we)      bus_out = z[WIDTH-1:0];
      else if (hi_we) bus_out = z[2*WIDTH-1:WIDTH];
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomised scoreboard bench for mul_seq_ctrl at settle times 2, 1 and 15, each instance
// paired with a behavioural multiplier and checked against a cycle-window reference model.
module tb_mul_seq_ctrl;

   localparam int NI = 3;

   typedef struct packed {
      int          acc;
      int          dm;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
   } exp_t;

   logic        clk;
   logic        clr_n;
   logic        start;
   logic [31:0] op_a, op_b;

   logic        busy_w [NI];
   logic        lo_we_w[NI];
   logic        hi_we_w[NI];
   logic        done_w [NI];
   logic [31:0] ma_w   [NI];
   logic [31:0] mb_w   [NI];
   logic [31:0] bus_w  [NI];
   logic [31:0] lo_w   [NI];
   logic [31:0] hi_w   [NI];
   logic [63:0] mp_w   [NI];

   function automatic int s_of(input int i);
      return (i == 0) ? 2 : (i == 1) ? 1 : 15;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int SG = (g == 0) ? 2 : (g == 1) ? 1 : 15;
      assign mp_w[g] = $signed({{32{ma_w[g][31]}}, ma_w[g]}) * $signed({{32{mb_w[g][31]}}, mb_w[g]});
      mul_seq_ctrl #(.WIDTH(32), .SETTLE_CYCLES(SG)) u_dut (
         .clk(clk), .clr_n(clr_n), .start(start), .op_a(op_a), .op_b(op_b),
         .mul_a(ma_w[g]), .mul_b(mb_w[g]), .mul_prod(mp_w[g]), .busy(busy_w[g]),
         .bus_out(bus_w[g]), .lo_we(lo_we_w[g]), .hi_we(hi_we_w[g]),
         .lo_out(lo_w[g]), .hi_out(hi_w[g]), .done(done_w[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          edges = 0;
   int          total = 0;
   int          passed = 0;
   bit          stim_done = 1'b0;
   int          free_at[NI];
   logic [31:0] lo_m[NI], hi_m[NI], la_m[NI], lb_m[NI];
   exp_t        q[NI][$];

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return sa * sb;
   endfunction

   task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s [S=%0d] edge %0d: got %h, expected %h", nm, s_of(i), edges, act, exp);
   endtask

   task automatic clear_model(input int i);
      q[i].delete();
      free_at[i] = 0;
      lo_m[i] = '0; hi_m[i] = '0; la_m[i] = '0; lb_m[i] = '0;
   endtask

   task automatic monitor(input int i);
      exp_t        e;
      bit          has;
      logic        x_lo, x_hi;
      logic [31:0] x_bus;
      if (!clr_n) begin
         clear_model(i);
         chk("rst_busy",  i, 64'(busy_w[i]),  64'd0);
         chk("rst_lo_we", i, 64'(lo_we_w[i]), 64'd0);
         chk("rst_hi_we", i, 64'(hi_we_w[i]), 64'd0);
         chk("rst_done",  i, 64'(done_w[i]),  64'd0);
         chk("rst_bus",   i, 64'(bus_w[i]),   64'd0);
         chk("rst_lo",    i, 64'(lo_w[i]),    64'd0);
         chk("rst_hi",    i, 64'(hi_w[i]),    64'd0);
         chk("rst_mul_a", i, 64'(ma_w[i]),    64'd0);
         chk("rst_mul_b", i, 64'(mb_w[i]),    64'd0);
         return;
      end
      has  = (q[i].size() != 0);
      e    = has ? q[i][0] : '0;
      x_lo = has && (edges == e.dm - 2);
      x_hi = has && (edges == e.dm - 1);
      x_bus = x_lo ? e.lo : (x_hi ? e.hi : 32'd0);
      chk("busy",    i, 64'(busy_w[i]),  64'(has && edges >= e.acc && edges <= e.dm));
      chk("lo_we",   i, 64'(lo_we_w[i]), 64'(x_lo));
      chk("hi_we",   i, 64'(hi_we_w[i]), 64'(x_hi));
      chk("done",    i, 64'(done_w[i]),  64'(has && edges == e.dm));
      chk("bus_out", i, 64'(bus_w[i]),   64'(x_bus));
      chk("lo_out",  i, 64'(lo_w[i]),    64'((has && edges >= e.dm - 1) ? e.lo : lo_m[i]));
      chk("hi_out",  i, 64'(hi_w[i]),    64'((has && edges >= e.dm) ? e.hi : hi_m[i]));
      chk("mul_a",   i, 64'(ma_w[i]),    64'(has ? e.a : la_m[i]));
      chk("mul_b",   i, 64'(mb_w[i]),    64'(has ? e.b : lb_m[i]));
      if (has && edges == e.dm) begin
         void'(q[i].pop_front());
         lo_m[i] = e.lo; hi_m[i] = e.hi; la_m[i] = e.a; lb_m[i] = e.b;
      end
   endtask

   // Reference model and monitor share one process: accept on the rising edge, compare on the falling edge.
   initial begin
      bit idle_all;
      for (int i = 0; i < NI; i++) clear_model(i);
      forever begin
         @(posedge clk);
         edges++;
         for (int i = 0; i < NI; i++) begin
            exp_t        e;
            logic [63:0] p;
            if (!clr_n) clear_model(i);
            else if (start && edges >= free_at[i]) begin
               p     = ref_prod(op_a, op_b);
               e.acc = edges;
               e.dm  = edges + s_of(i) + 2;
               e.a   = op_a;
               e.b   = op_b;
               e.lo  = p[31:0];
               e.hi  = p[63:32];
               q[i].push_back(e);
               free_at[i] = edges + s_of(i) + 4;
            end
         end
         @(negedge clk);
         for (int i = 0; i < NI; i++) monitor(i);
         idle_all = 1'b1;
         for (int i = 0; i < NI; i++) if (q[i].size() != 0) idle_all = 1'b0;
         if (stim_done && idle_all) begin
            $display("%0d/%0d checks passed", passed, total);
            $finish;
         end
         if (edges > 20000) begin
            total++;
            $display("FAIL watchdog: edge %0d reached, expected completion before 20000", edges);
            $display("%0d/%0d checks passed", passed, total);
            $finish;
         end
      end
   end

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic idle_wait();
      repeat (22) @(negedge clk);
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b;
      @(negedge clk);
      start = 1'b0;
      idle_wait();
   endtask

   initial begin
      clr_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
      repeat (3) @(negedge clk);
      #1 clr_n = 1'b1;

      run(32'd3, 32'd5);
      run(32'hFFFF_FFFE, 32'd3);
      run(32'h8000_0000, 32'h8000_0000);
      run(32'h7FFF_FFFF, 32'h8000_0000);

      // start while busy and operand change during SETTLE must not affect 7x6
      @(negedge clk); start = 1'b1; op_a = 32'd7;   op_b = 32'd6;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1; op_a = 32'd100; op_b = 32'd100;
      @(negedge clk); start = 1'b0; op_a = 32'd55;
      idle_wait();

      // asynchronous abort in the middle of an operation
      @(negedge clk); start = 1'b1; op_a = 32'd9; op_b = 32'd9;
      @(negedge clk); start = 1'b0;
      @(posedge clk); #2 clr_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 clr_n = 1'b1;
      run(32'd2, 32'd2);

      // start held high: back-to-back operations with changing operands
      @(negedge clk); start = 1'b1;
      repeat (60) begin
         @(negedge clk); op_a = $urandom; op_b = $urandom;
      end
      start = 1'b0;
      idle_wait();

      repeat (400) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         op_a  = rnd_op();
         op_b  = rnd_op();
      end
      @(negedge clk); start = 1'b0;
      idle_wait();
      stim_done = 1'b1;
   end

endmodule
